// File: rtl/ccta_pkg.sv
// rtl/ccta_pkg.sv - shared width, state type and operand extension for the CCTA result accumulator
package ccta_pkg;

    localparam int Q_W = 5;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } ccta_state_e;

    // Returns q widened to acc_w bits (zero- or sign-extended by ctrl); bits above acc_w are cleared.
    function automatic logic [31:0] ccta_ext(input logic [Q_W-1:0] q, input logic ctrl, input int acc_w);
        logic [31:0] r;
        r = ctrl ? {{(32-Q_W){q[Q_W-1]}}, q} : {{(32-Q_W){1'b0}}, q};
        for (int i = 0; i < 32; i++) begin
            if (i >= acc_w) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ccta_sat_add.sv
// rtl/ccta_sat_add.sv - combinational signed add clamped to the operand width
module ccta_sat_add #(
    parameter int W = 9
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    logic signed [W-1:0] raw;

    // Overflow only possible when both operands share a sign and the result flips it.
    always_comb begin
        raw = a + b;
        ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
        if (!ovf) begin
            sum = raw;
        end else if (a[W-1]) begin
            sum = {1'b1, {(W-1){1'b0}}};
        end else begin
            sum = {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/ccta_result_accum.sv
// rtl/ccta_result_accum.sv - windowed saturating accumulator of CCTA results with valid/ready output
module ccta_result_accum
    import ccta_pkg::*;
#(
    parameter int NSAMP = 8,
    parameter int ACC_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [Q_W-1:0]   q_in,
    input  logic             ctrl_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic             sat_out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSAMP - 1);

    ccta_state_e             state;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] ext_q;
    logic signed [ACC_W-1:0] acc_next;
    logic                    sat;
    logic                    ovf;
    logic                    sat_next;
    logic                    accept;

    assign ext_q    = ACC_W'(ccta_ext(q_in, ctrl_in, ACC_W));
    assign sat_next = sat | ovf;
    assign in_ready = (state == ACCUM);
    assign accept   = in_valid & in_ready;

    ccta_sat_add #(.W(ACC_W)) u_add (
        .a   (acc),
        .b   (ext_q),
        .sum (acc_next),
        .ovf (ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            sum_out   <= '0;
            sat_out   <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            // sum_out deliberately untouched; it is meaningless while out_valid is low.
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            sum_out   <= acc_next;
                            sat_out   <= sat_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                            acc       <= '0;
                            cnt       <= '0;
                            sat       <= 1'b0;
                        end else begin
                            acc <= acc_next;
                            sat <= sat_next;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        sat       <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_ccta_result_accum.sv
// tb/tb_ccta_result_accum.sv - self-checking bench for ccta_result_accum (NSAMP=8 and NSAMP=16 instances)
module tb_ccta_result_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [4:0] q_in      [2];
    logic       ctrl_in   [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [8:0] sum_out   [2];
    logic       sat_out   [2];
    logic       out_valid [2];
    logic       out_ready [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ccta_result_accum #(.NSAMP(8), .ACC_W(9)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .q_in(q_in[0]), .ctrl_in(ctrl_in[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .sum_out(sum_out[0]), .sat_out(sat_out[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0])
    );

    ccta_result_accum #(.NSAMP(16), .ACC_W(9)) dut16 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .q_in(q_in[1]), .ctrl_in(ctrl_in[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .sum_out(sum_out[1]), .sat_out(sat_out[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window model: running saturated sum per instance, plus the held result.
    int m_acc [2], m_cnt [2], m_osum [2], accepted [2];
    bit m_sat [2], m_osat [2], m_busy [2];
    bit m_live = 0;

    function automatic int ext_val(input logic [4:0] q, input logic c);
        int v;
        v = int'(q);
        if (c && v >= 16) v = v - 32;
        return v;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
                m_busy[k] = 0; m_osum[k] = 0; m_osat[k] = 0;
            end else if (clr) begin
                m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; m_busy[k] = 0;
            end else if (m_busy[k]) begin
                if (out_ready[k]) m_busy[k] = 0;
            end else if (in_valid[k]) begin
                int s;
                accepted[k]++;
                s = m_acc[k] + ext_val(q_in[k], ctrl_in[k]);
                if (s > 255)  begin s = 255;  m_sat[k] = 1; end
                if (s < -256) begin s = -256; m_sat[k] = 1; end
                m_acc[k] = s;
                m_cnt[k]++;
                if (m_cnt[k] == ((k == 0) ? 8 : 16)) begin
                    m_osum[k] = m_acc[k]; m_osat[k] = m_sat[k]; m_busy[k] = 1;
                    m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
                end
            end
        end
        m_live = 1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("in_ready[%0d]", k), int'(in_ready[k]), int'(!m_busy[k]));
                chk($sformatf("out_valid[%0d]", k), int'(out_valid[k]), int'(m_busy[k]));
                if (m_busy[k]) begin
                    chk($sformatf("sum_out[%0d]", k), $signed(sum_out[k]), m_osum[k]);
                    chk($sformatf("sat_out[%0d]", k), int'(sat_out[k]), int'(m_osat[k]));
                end
            end
        end
    end

    task automatic send(input int k, input logic [4:0] q, input logic c);
        int n;
        q_in[k] = q; ctrl_in[k] = c; in_valid[k] = 1'b1;
        n = 0;
        while (!in_ready[k] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic window(input int k, input int n, input logic [4:0] q, input logic c);
        for (int i = 0; i < n; i++) send(k, q, c);
        in_valid[k] = 1'b0;
        chk("latency_out_valid", int'(out_valid[k]), 1);
    endtask

    task automatic finish_win(input int k, input int exp_sum, input int exp_sat);
        chk("lit_sum", $signed(sum_out[k]), exp_sum);
        chk("lit_sat", int'(sat_out[k]), exp_sat);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk("handoff_drop", int'(out_valid[k]), 0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            q_in[k] = '0; ctrl_in[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0; accepted[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", int'(out_valid[k]), 0);
            chk("rst_sum", int'(sum_out[k]), 0);
            chk("rst_sat", int'(sat_out[k]), 0);
            chk("rst_in_ready", int'(in_ready[k]), 1);
        end

        window(0, 8, 5'd30, 1'b0);
        finish_win(0, 240, 0);
        window(0, 8, 5'b10001, 1'b1);
        chk("lit_sum_hex", int'(sum_out[0]), 'h188);
        finish_win(0, -120, 0);
        for (int i = 0; i < 4; i++) begin
            send(0, 5'd30, 1'b0);
            send(0, 5'b10001, 1'b1);
        end
        in_valid[0] = 1'b0;
        finish_win(0, 60, 0);

        window(1, 16, 5'd30, 1'b0);
        chk("lit_sum_hex16", int'(sum_out[1]), 'h0FF);
        finish_win(1, 255, 1);
        window(1, 16, 5'd1, 1'b0);
        finish_win(1, 16, 0);

        for (int i = 0; i < 8; i++) send(0, 5'd2, 1'b0);
        base = accepted[0];
        q_in[0] = 5'd7; in_valid[0] = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_in_ready", int'(in_ready[0]), 0);
            chk("bp_sum", $signed(sum_out[0]), 16);
        end
        chk("bp_consumed", accepted[0] - base, 0);
        in_valid[0] = 1'b0;
        finish_win(0, 16, 0);
        window(0, 8, 5'd3, 1'b0);
        finish_win(0, 24, 0);

        for (int i = 0; i < 3; i++) send(0, 5'd5, 1'b0);
        clr = 1'b1; q_in[0] = 5'd5; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; in_valid[0] = 1'b0;
        base = accepted[0];
        window(0, 8, 5'd1, 1'b0);
        chk("clr_accepted", accepted[0] - base, 8);
        finish_win(0, 8, 0);

        for (int i = 0; i < 3; i++) send(0, 5'd9, 1'b0);
        rst_n = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid[0] = 1'b0;
        base = accepted[0];
        window(0, 8, 5'd1, 1'b0);
        chk("rst_accepted", accepted[0] - base, 8);
        finish_win(0, 8, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
